// File: rtl/wb_stage_if.sv
// Write-back stage bus: MEM-side request, register-file write port and decode forwarding lookup.
// The slave modport is the write-back stage itself; master is everything around it.
interface wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2
);
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_sel;
    logic [DATA_W-1:0] in_alu;
    logic [DATA_W-1:0] in_mem;
    logic [DATA_W-1:0] in_link;
    logic [1:0]        in_ld_size;
    logic              in_ld_sgn;
    logic [OFF_W-1:0]  in_off;
    logic [REG_AW-1:0] in_rd;
    logic              in_wen;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_ready;
    logic [REG_AW-1:0] fwd_raddr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [OCC_W-1:0]  occ;

    modport slave (
        input  in_valid, in_sel, in_alu, in_mem, in_link, in_ld_size, in_ld_sgn,
               in_off, in_rd, in_wen, rf_ready, fwd_raddr,
        output in_ready, rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data, occ
    );

    modport master (
        output in_valid, in_sel, in_alu, in_mem, in_link, in_ld_size, in_ld_sgn,
               in_off, in_rd, in_wen, rf_ready, fwd_raddr,
        input  in_ready, rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data, occ
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: result select, load align/extend, DEPTH-entry register-write queue
// draining into the register file, with youngest-wins forwarding over queued entries.
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2
) (
    input  logic     clk,
    input  logic     nrst,
    wb_stage_if.slave bus
);
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             fifo [DEPTH];
    entry_t             last_q;
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, idx;
    logic [OCC_W-1:0]   occ_q;
    logic [OFF_W-1:0]   off_m;
    logic [DATA_W-1:0]  lane, ld, wmask, tmask, result, fdata;
    int                 width;
    logic               enq, deq, hit;

    // Load extraction: offset is forced to the access-size alignment before shifting.
    always_comb begin
        off_m = bus.in_off;
        width = 32;
        case (bus.in_ld_size)
            2'd0: width = 8;
            2'd1: begin off_m = bus.in_off & ~OFF_W'(1); width = 16; end
            2'd2: begin off_m = bus.in_off & ~OFF_W'(3); width = 32; end
            default: begin
                if (DATA_W == 64) begin off_m = '0; width = 64; end
                else begin off_m = bus.in_off & ~OFF_W'(3); width = 32; end
            end
        endcase
        lane = bus.in_mem >> {off_m, 3'b000};
        for (int i = 0; i < DATA_W; i++) begin
            wmask[i] = (i < width);
            tmask[i] = (i == width - 1);
        end
        ld = lane & wmask;
        if (bus.in_ld_sgn && |(lane & tmask)) ld = ld | ~wmask;
        case (bus.in_sel)
            2'd1:    result = ld;
            2'd2:    result = bus.in_link;
            default: result = bus.in_alu;
        endcase
    end

    assign bus.in_ready = (occ_q != OCC_W'(DEPTH));
    assign enq = bus.in_valid && bus.in_ready && bus.in_wen && (bus.in_rd != '0);
    assign deq = (occ_q != '0) && bus.rf_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
            last_q <= '0;
            for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
        end else begin
            if (enq) begin
                fifo[wr_ptr] <= '{rd: bus.in_rd, data: result};
                wr_ptr       <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                last_q <= fifo[rd_ptr];
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ_q <= occ_q + OCC_W'(enq) - OCC_W'(deq);
        end
    end

    // When empty the port keeps showing the last retired entry rather than stale slots.
    assign head         = (occ_q != '0) ? fifo[rd_ptr] : last_q;
    assign bus.rf_we    = (occ_q != '0);
    assign bus.rf_waddr = head.rd;
    assign bus.rf_wdata = head.data;
    assign bus.occ      = occ_q;

    // Walk oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        hit   = 1'b0;
        fdata = '0;
        idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if ((OCC_W'(k) < occ_q) && (bus.fwd_raddr != '0) && (fifo[idx].rd == bus.fwd_raddr)) begin
                hit   = 1'b1;
                fdata = fifo[idx].data;
            end
        end
    end

    assign bus.fwd_hit  = hit;
    assign bus.fwd_data = fdata;
endmodule
